sdf_delay_line: RTL and testbench

Parametrised complex-sample delay line for the single-path delay-feedback (SDF) FFT stages. It is the generalised successor to the fixed 32-deep shifter: width and depth are configurable, and it tracks per-entry validity. It drives a frame-phase bit for butterfly bypass/compute selection and drains itself automatically when the input stream stops. One instance sits in the feedback path of each radix-2 stage, with DEPTH = N/2, N/4, … down to 1.

---
 rtl/sdf_delay_line.sv | 121 ++++++++++++
 tb/tb_sdf_delay_line.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: complex-sample delay line for the feedback path of one
// radix-2 SDF FFT stage. Delays {re, im} by exactly DEPTH advances, tags each
// entry with its input validity, produces the frame-phase bit for butterfly
// bypass/compute selection, and reports how many valid entries are held.
//
// Optional feature macro: SDF_DELAY_DRAIN_EN
//   defined   : when the input stops, the line keeps advancing with zero fill
//               until every valid entry has left; cnt clears when it empties.
//   undefined : the line advances only on in_valid and freezes otherwise.
//
// Ports:
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   in_valid   din_r/din_i carry a valid sample this cycle
//   din_r/i    signed real/imaginary input
//   dout_r/i   signed real/imaginary of the oldest entry (registered)
//   out_valid  oldest entry entered with in_valid=1 (registered)
//   adv        combinational; the line shifts at this clock edge
//   phase      0 = first DEPTH advances of a frame, 1 = second DEPTH advances
//   occ        number of valid-tagged entries in the line (registered)
module sdf_delay_line #(
   parameter  int unsigned DATA_W = 24,
   parameter  int unsigned DEPTH  = 32,
   localparam int unsigned CW     = $clog2(DEPTH) + 1,
   localparam int unsigned OW     = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] din_r,
   input  logic signed [DATA_W-1:0] din_i,
   output logic signed [DATA_W-1:0] dout_r,
   output logic signed [DATA_W-1:0] dout_i,
   output logic                     out_valid,
   output logic                     adv,
   output logic                     phase,
   output logic [OW-1:0]            occ
);

   typedef struct packed {
      logic                     tag;
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } entry_t;

   // chain[0] is the value loaded into the newest entry; chain[g+1] is entry g.
   entry_t          chain [DEPTH+1];
   entry_t          head_d;
   entry_t          tail;
   logic            drain_c;
   logic            adv_c;
   logic            done_c;
   logic [OW-1:0]   occ_q;
   logic [OW-1:0]   occ_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;

   // Value entering entry 0: the input sample, or zero fill while draining.
   always_comb begin
      head_d = '0;
      if (in_valid) begin
         head_d.tag = 1'b1;
         head_d.re  = din_r;
         head_d.im  = din_i;
      end
   end

   // Advance decision: drain only exists with the feature enabled.
   always_comb begin
      drain_c = 1'b0;
`ifdef SDF_DELAY_DRAIN_EN
      drain_c = !in_valid && (occ_q != '0);
`endif
      adv_c = in_valid || drain_c;
   end

   // Occupancy and phase-counter next state; the last drain step re-aligns cnt.
   always_comb begin
      occ_d  = occ_q + OW'(in_valid) - OW'(tail.tag);
      done_c = drain_c && (occ_d == '0);
      cnt_d  = done_c ? '0 : cnt_q + CW'(1);
   end

   assign chain[0] = head_d;

   // Shift chain: every entry moves one place toward DEPTH-1 on each advance.
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      entry_t q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (adv_c) begin
            q <= chain[g];
         end
      end

      assign chain[g+1] = q;
   end

   assign tail = chain[DEPTH];

   // Occupancy and frame counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
         cnt_q <= '0;
      end else if (adv_c) begin
         occ_q <= occ_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout_r    = tail.re;
   assign dout_i    = tail.im;
   assign out_valid = tail.tag;
   assign adv       = adv_c;
   assign phase     = cnt_q[CW-1];
   assign occ       = occ_q;

endmodule

// File: tb/tb_sdf_delay_line.sv
// Self-checking bench for sdf_delay_line: table-driven directed vectors on a
// DEPTH=32 / DATA_W=24 instance and a DEPTH=1 / DATA_W=16 instance, plus
// hand-written reset sequences. Expectations follow the build's drain macro.
module tb_sdf_delay_line;

   localparam int unsigned DW  = 24;
   localparam int unsigned D   = 32;
   localparam int unsigned OW  = 6;
   localparam int unsigned DW1 = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                 in_valid;
   logic signed [DW-1:0] din_r, din_i, dout_r, dout_i;
   logic                 out_valid, adv, phase;
   logic [OW-1:0]        occ;

   logic                  in_valid1;
   logic signed [DW1-1:0] din1_r, din1_i, dout1_r, dout1_i;
   logic                  out_valid1, adv1, phase1;
   logic [0:0]            occ1;

   sdf_delay_line #(.DATA_W(DW), .DEPTH(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .dout_r    (dout_r),
      .dout_i    (dout_i),
      .out_valid (out_valid),
      .adv       (adv),
      .phase     (phase),
      .occ       (occ)
   );

   sdf_delay_line #(.DATA_W(DW1), .DEPTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .din_r     (din1_r),
      .din_i     (din1_i),
      .dout_r    (dout1_r),
      .dout_i    (dout1_i),
      .out_valid (out_valid1),
      .adv       (adv1),
      .phase     (phase1),
      .occ       (occ1)
   );

   typedef struct {
      logic iv;
      int   dr;
      int   di;
      logic e_adv;
      int   e_dr;
      int   e_di;
      logic e_ov;
      logic e_ph;
      int   e_occ;
   } vec_t;

   vec_t tbl[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(logic iv, int dr, int di, logic a, int er, int ei,
                               logic ov, logic ph, int oc);
      vec_t v;
      v.iv = iv; v.dr = dr; v.di = di;
      v.e_adv = a; v.e_dr = er; v.e_di = ei; v.e_ov = ov; v.e_ph = ph; v.e_occ = oc;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic signed [31:0] act, input logic signed [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   // Apply each vector after a rising edge, compare on the falling edge.
   task automatic run_main(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         in_valid = tbl[i].iv;
         din_r    = DW'(tbl[i].dr);
         din_i    = DW'(tbl[i].di);
         @(negedge clk);
         check({name, ".adv"},       i, adv,       tbl[i].e_adv);
         check({name, ".dout_r"},    i, dout_r,    tbl[i].e_dr);
         check({name, ".dout_i"},    i, dout_i,    tbl[i].e_di);
         check({name, ".out_valid"}, i, out_valid, tbl[i].e_ov);
         check({name, ".phase"},     i, phase,     tbl[i].e_ph);
         check({name, ".occ"},       i, occ,       tbl[i].e_occ);
         @(posedge clk);
         #1;
      end
      tbl.delete();
   endtask

   task automatic run_d1(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         in_valid1 = tbl[i].iv;
         din1_r    = DW1'(tbl[i].dr);
         din1_i    = DW1'(tbl[i].di);
         @(negedge clk);
         check({name, ".adv"},       i, adv1,       tbl[i].e_adv);
         check({name, ".dout_r"},    i, dout1_r,    tbl[i].e_dr);
         check({name, ".dout_i"},    i, dout1_i,    tbl[i].e_di);
         check({name, ".out_valid"}, i, out_valid1, tbl[i].e_ov);
         check({name, ".phase"},     i, phase1,     tbl[i].e_ph);
         check({name, ".occ"},       i, occ1,       tbl[i].e_occ);
         @(posedge clk);
         #1;
      end
      tbl.delete();
      in_valid1 = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      din_r     = '0;
      din_i     = '0;
      in_valid1 = 1'b0;
      din1_r    = '0;
      din1_i    = '0;

      // Reset state of both instances
      #12;
      check("rst.dout_r", 0, dout_r, 0);
      check("rst.dout_i", 0, dout_i, 0);
      check("rst.out_valid", 0, out_valid, 0);
      check("rst.phase", 0, phase, 0);
      check("rst.occ", 0, occ, 0);
      check("rst.adv", 0, adv, 0);
      check("rst1.dout_r", 0, dout1_r, 0);
      check("rst1.occ", 0, occ1, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // DEPTH=1, 16-bit extremes pass bit-exact; phase toggles every advance
      tbl.push_back(mk(1, 32767, 4660, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, -32768, -1, 1, 32767, 4660, 1, 1, 1));
`ifdef SDF_DELAY_DRAIN_EN
      tbl.push_back(mk(0, 5, 5, 1, -32768, -1, 1, 0, 1));
      tbl.push_back(mk(0, 5, 5, 0, 0, 0, 0, 0, 0));
`else
      tbl.push_back(mk(0, 5, 5, 0, -32768, -1, 1, 0, 1));
      tbl.push_back(mk(0, 5, 5, 0, -32768, -1, 1, 0, 1));
`endif
      run_d1("d1");

      // Continuous stream din_r=k, din_i=-k for k=0..63
      for (int k = 0; k < 64; k++) begin
         if (k >= 32) tbl.push_back(mk(1, k, -k, 1, k - 32, 32 - k, 1, 1, 32));
         else         tbl.push_back(mk(1, k, -k, 1, 0, 0, 0, 0, k));
      end
      run_main("stream");

      // Asynchronous reset mid-stream with a full line
      in_valid = 1'b1;
      din_r    = DW'(77);
      din_i    = DW'(-77);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.dout_r", 0, dout_r, 0);
      check("midrst.dout_i", 0, dout_i, 0);
      check("midrst.out_valid", 0, out_valid, 0);
      check("midrst.phase", 0, phase, 0);
      check("midrst.occ", 0, occ, 0);
      check("midrst.adv", 0, adv, 1);
      in_valid = 1'b0;
      #1;
      check("midrst.adv", 1, adv, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef SDF_DELAY_DRAIN_EN
      // Drain: 10 samples then idle; zero fill, cnt cleared on the last step
      for (int c = 0; c < 46; c++) begin
         int e;
         e = (c >= 32 && c <= 41) ? c - 32 : 0;
         tbl.push_back(mk(c < 10, c < 10 ? c : 1445, c < 10 ? -c : 1445,
                          c <= 41, e, -e, c >= 32 && c <= 41, c >= 32 && c <= 41,
                          c <= 10 ? c : (c <= 32 ? 10 : (c <= 41 ? 42 - c : 0))));
      end
      run_main("drain");

      // Resume mid-drain: new stream from advance 20, no gap, no cnt clear
      for (int c = 0; c < 56; c++) begin
         int   e;
         logic ov;
         int   oc;
         if (c >= 32 && c <= 41)  begin e = c - 32;       ov = 1'b1; end
         else if (c >= 52)        begin e = 100 + c - 52; ov = 1'b1; end
         else                     begin e = 0;            ov = 1'b0; end
         if (c <= 10)      oc = c;
         else if (c <= 20) oc = 10;
         else if (c <= 32) oc = c - 10;
         else if (c <= 42) oc = 22;
         else              oc = (c - 20 > 32) ? 32 : c - 20;
         if (c < 10)       tbl.push_back(mk(1, c, -c, 1, e, -e, ov, c >= 32, oc));
         else if (c < 20)  tbl.push_back(mk(0, 1445, 1445, 1, e, -e, ov, c >= 32, oc));
         else              tbl.push_back(mk(1, 100 + c - 20, -(100 + c - 20), 1, e, -e,
                                            ov, c >= 32, oc));
      end
      run_main("resume");
`else
      // Input stops: line freezes holding its 10 valid entries
      for (int c = 0; c < 15; c++) begin
         if (c < 10) tbl.push_back(mk(1, c, -c, 1, 0, 0, 0, 0, c));
         else        tbl.push_back(mk(0, 1445, 1445, 0, 0, 0, 0, 0, 10));
      end
      run_main("freeze");
      do_reset();

      // Bubbles: alternate valid/idle; state frozen on idle cycles
      for (int t = 0; t < 66; t++) begin
         int j;
         int k;
         j = t / 2;
         if (t % 2 == 0) begin
            tbl.push_back(mk(1, 200 + j, -(200 + j), 1,
                             j >= 32 ? 200 + j - 32 : 0, j >= 32 ? -(200 + j - 32) : 0,
                             j >= 32, j >= 32, j >= 32 ? 32 : j));
         end else begin
            k = j + 1;
            tbl.push_back(mk(0, 1445, 1445, 0,
                             k >= 32 ? 200 + k - 32 : 0, k >= 32 ? -(200 + k - 32) : 0,
                             k >= 32, k >= 32, k >= 32 ? 32 : k));
         end
      end
      run_main("bubble");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
